// File: rtl/scheduler_unit.sv
// scheduler_unit: interrupt/timer scheduler with vectored requests and saved-PC return.
// Build option: define SCHED_DMA_INT_EN to enable the DMA interrupt source.
module scheduler_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        SCHED_conf,
    input  logic [3:0]  SCHED_OP,
    input  logic [15:0] SCHED_value,
    input  logic [15:0] PC_pos,
    input  logic        SYSCALL_req,
    input  logic        DMA_done,
    input  logic        INT_ack,
    output logic        INT_req,
    output logic [15:0] INT_addr,
    output logic [15:0] SCHED_out,
    output logic        SCHED_out_valid,
    output logic        running
);
`ifdef SCHED_DMA_INT_EN
    localparam logic DMA_EN = 1'b1;
`else
    localparam logic DMA_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, REQ, ISR} state_t;
    state_t      state_q, state_d;
    logic [15:0] sys_vec_q, sys_vec_d, tmr_vec_q, tmr_vec_d, dma_vec_q, dma_vec_d;
    logic [15:0] period_q, period_d, count_q, count_d, saved_q, saved_d;
    logic [15:0] addr_q, addr_d, out_q, out_d;
    logic        vld_q, vld_d;
    logic [2:0]  pend_q, pend_d, sel_q, sel_d, clr;
    logic        tick;
    always_comb begin
        state_d   = state_q;
        sys_vec_d = sys_vec_q;
        tmr_vec_d = tmr_vec_q;
        dma_vec_d = dma_vec_q;
        period_d  = period_q;
        count_d   = count_q;
        saved_d   = saved_q;
        addr_d    = addr_q;
        out_d     = out_q;
        vld_d     = 1'b0;
        sel_d     = sel_q;
        clr       = 3'b000;
        tick      = 1'b0;
        if ((state_q == RUN || state_q == ISR) && period_q != 16'd0) begin
            tick    = count_q == period_q - 16'd1;
            count_d = tick ? 16'd0 : count_q + 16'd1;
        end
        // Source priority is syscall > DMA > timer; the vector is captured before any same-edge write.
        if (state_q == RUN && pend_q != 3'b000) begin
            state_d = REQ;
            sel_d   = pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : 3'b100;
            addr_d  = pend_q[0] ? sys_vec_q : pend_q[1] ? dma_vec_q : tmr_vec_q;
        end
        if (state_q == REQ && INT_ack) begin
            state_d = ISR;
            saved_d = PC_pos;
            clr     = sel_q;
        end
        pend_d = pend_q & ~clr;
        if (state_q != IDLE)
            pend_d = pend_d | {tick, DMA_EN & DMA_done, SYSCALL_req};
        if (SCHED_conf) begin
            case (SCHED_OP)
                4'b0001: sys_vec_d = SCHED_value;
                4'b0010: tmr_vec_d = SCHED_value;
                4'b0011: dma_vec_d = DMA_EN ? SCHED_value : dma_vec_q;
                4'b0100: begin
                    period_d = SCHED_value;
                    count_d  = 16'd0;
                    state_d  = (state_q == IDLE) ? RUN : state_d;
                end
                4'b0101: count_d = 16'd0;
                4'b0110: begin
                    out_d   = saved_q;
                    vld_d   = 1'b1;
                    state_d = (state_q == ISR) ? RUN : state_d;
                end
                4'b0111: begin
                    out_d = PC_pos;
                    vld_d = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sys_vec_q <= '0;
            tmr_vec_q <= '0;
            dma_vec_q <= '0;
            period_q  <= '0;
            count_q   <= '0;
            saved_q   <= '0;
            addr_q    <= '0;
            out_q     <= '0;
            vld_q     <= 1'b0;
            pend_q    <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            sys_vec_q <= sys_vec_d;
            tmr_vec_q <= tmr_vec_d;
            dma_vec_q <= dma_vec_d;
            period_q  <= period_d;
            count_q   <= count_d;
            saved_q   <= saved_d;
            addr_q    <= addr_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
            pend_q    <= pend_d;
            sel_q     <= sel_d;
        end
    end
    assign INT_req         = state_q == REQ;
    assign INT_addr        = addr_q;
    assign SCHED_out       = out_q;
    assign SCHED_out_valid = vld_q;
    assign running         = state_q != IDLE;
endmodule

// File: tb/tb_scheduler_unit.sv
// tb_scheduler_unit: table-driven, scoreboarded check of scheduler_unit (DMA build follows SCHED_DMA_INT_EN).
module tb_scheduler_unit;
`ifdef SCHED_DMA_INT_EN
    localparam bit D = 1'b1;
`else
    localparam bit D = 1'b0;
`endif
    typedef struct {
        logic        rst, conf, sys, dma, ack;
        logic [3:0]  op;
        logic [15:0] val, pc;
        logic        req, vld, run;
        logic [15:0] addr, out;
    } vec_t;
    logic        clk = 1'b0, rst = 1'b1, conf = 1'b0, sys = 1'b0, dma = 1'b0, ack = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] val = '0, pc = '0;
    logic        int_req, out_valid, running;
    logic [15:0] int_addr, sched_out;
    int          checks = 0, errors = 0;
    vec_t        tbl[$];
    vec_t        sb[$];
    scheduler_unit dut (
        .clock(clk), .reset(rst), .SCHED_conf(conf), .SCHED_OP(op), .SCHED_value(val),
        .PC_pos(pc), .SYSCALL_req(sys), .DMA_done(dma), .INT_ack(ack),
        .INT_req(int_req), .INT_addr(int_addr), .SCHED_out(sched_out),
        .SCHED_out_valid(out_valid), .running(running)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic r, c, input logic [3:0] o, input logic [15:0] v, p,
                                input logic s, d, a, q, input logic [15:0] ad, ou, input logic vl, rn);
        vec_t x;
        x.rst = r; x.conf = c; x.op = o; x.val = v; x.pc = p; x.sys = s; x.dma = d; x.ack = a;
        x.req = q; x.addr = ad; x.out = ou; x.vld = vl; x.run = rn;
        return x;
    endfunction
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        rst = v.rst; conf = v.conf; op = v.op; val = v.val; pc = v.pc;
        sys = v.sys; dma = v.dma; ack = v.ack;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " INT_req"}, {15'd0, int_req}, {15'd0, e.req});
        chk({tag, " INT_addr"}, int_addr, e.addr);
        chk({tag, " SCHED_out"}, sched_out, e.out);
        chk({tag, " SCHED_out_valid"}, {15'd0, out_valid}, {15'd0, e.vld});
        chk({tag, " running"}, {15'd0, running}, {15'd0, e.run});
    endtask
    initial begin
        logic [15:0] a2, o26, o29;
        a2  = D ? 16'h0200 : 16'h0100;
        o26 = D ? 16'h0060 : 16'h0050;
        o29 = D ? 16'h0070 : 16'h0050;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0100, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 2, 16'h0300, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 3, 16'h0200, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 4, 16'd5, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0300, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0300, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0040, 0, 0, 1, 0, 16'h0300, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 1, 4, 16'd0, 0, 0, 0, 0, 0, 16'h0300, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, 16'h0300, 16'h0040, 1, 1));
        tbl.push_back(mk(0, 1, 7, 0, 16'h1234, 0, 0, 0, 0, 16'h0300, 16'h1234, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0300, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 1, 7, 0, 16'h2222, 1, 1, 0, 0, 16'h0300, 16'h2222, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100, 16'h2222, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0050, 0, 0, 1, 0, 16'h0100, 16'h2222, 0, 1));
        tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, 16'h0100, 16'h0050, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, D, a2, 16'h0050, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0060, 0, 0, 1, 0, a2, 16'h0050, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, a2, 16'h0050, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, a2, 16'h0050, 0, 1));
        tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, a2, o26, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, D, a2, o26, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0070, 0, 0, 1, 0, a2, o26, 0, 1));
        tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, a2, o29, 1, 1));
        foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, a2, o29, 0, 1), "sys_evt");
        step(mk(0, 1, 1, 16'h0ABC, 0, 0, 0, 0, 1, 16'h0100, o29, 0, 1), "freeze_vec");
        step(mk(0, 0, 0, 0, 16'h0080, 0, 0, 1, 0, 16'h0100, o29, 0, 1), "ack2");
        step(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, 16'h0100, 16'h0080, 1, 1), "retr2");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0100, 16'h0080, 0, 1), "sys_evt2");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0ABC, 16'h0080, 0, 1), "new_vec");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0), "rst_in_req");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0), "idle_sys");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0), "idle_after");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scheduler_unit.md
SCHEDULER_UNIT -- requirements
Module: scheduler_unit

Interface
REQ-001 clock  in  1  single clock; all state changes on the rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 SCHED_conf  in  1  command strobe from the scheduler decoder; one command per cycle while high.
REQ-004 SCHED_OP  in  4  command code: 0001 SYSCall vector, 0010 Timer vector, 0011 DMA vector, 0100 Start, 0101 RTimer, 0110 RETR, 0111 PC.
REQ-005 SCHED_value  in  16  command operand (vector address or timer period).
REQ-006 PC_pos  in  16  current program counter.
REQ-007 SYSCALL_req  in  1  single-cycle software-interrupt event.
REQ-008 DMA_done  in  1  single-cycle DMA-completion event.
REQ-009 INT_ack  in  1  core has taken the jump to INT_addr.
REQ-010 INT_req  out  1  interrupt request to the core; held until acknowledged.
REQ-011 INT_addr  out  16  handler vector; valid while INT_req is high.
REQ-012 SCHED_out  out  16  returned PC value.
REQ-013 SCHED_out_valid  out  1  one-cycle strobe qualifying SCHED_out.
REQ-014 running  out  1  high once Start has executed.

Function
REQ-015 Commands are accepted only when SCHED_conf=1; they take effect at the same edge and are visible from the next cycle.
REQ-016 Opcodes 0001, 0010 and 0011 load the syscall, timer and DMA vector registers from SCHED_value.
REQ-017 Start (0100) loads the timer period from SCHED_value, clears the timer count and sets running; when already running it only reloads and clears.
REQ-018 RTimer (0101) clears the timer count; the operand is ignored.
REQ-019 RETR (0110) drives SCHED_out=saved_PC with SCHED_out_valid=1 on the next cycle; from ISR it returns to RUN, elsewhere it causes no state change.
REQ-020 PC (0111) drives SCHED_out=PC_pos (sampled at the command edge) with SCHED_out_valid=1 on the next cycle.
REQ-021 Undefined opcodes are no-ops.
REQ-022 Timer: 16-bit count increments in RUN and ISR; when count==period-1 it wraps to 0 and sets timer_pend; period 0 disables the timer.
REQ-023 Pending flags: sys_pend, dma_pend and timer_pend are set by their events and cleared only when that source is acknowledged; a repeat event while pending is absorbed.
REQ-024 States: IDLE (after reset, until Start) -> RUN; in RUN with any pending flag -> REQ; in REQ with INT_ack -> ISR; in ISR with RETR -> RUN.
REQ-025 In IDLE, events are ignored and no flag is set.
REQ-026 In REQ, INT_req=1 and INT_addr is the vector of the highest pending source: syscall > DMA > timer. The selection is frozen on entry to REQ.
REQ-027 On INT_ack in REQ: saved_PC:=PC_pos, the selected pending flag clears, INT_req drops the next cycle.
REQ-028 INT_ack outside REQ is ignored.
REQ-029 In ISR, interrupts are masked and events still latch; they are serviced after RETR (next RUN cycle -> REQ).
REQ-030 An event and a command in the same cycle are both honoured.
REQ-031 A vector write in the same cycle as entry to REQ does not change the frozen INT_addr.

Reset
REQ-032 On reset, state returns to IDLE and all outputs go to 0: INT_req, INT_addr, SCHED_out, SCHED_out_valid, running.
REQ-033 On reset, the vectors, period, count, saved_PC and all pending flags clear, including mid-ISR and mid-REQ.

Configuration
REQ-034 The macro SCHED_DMA_INT_EN controls the DMA interrupt source.
REQ-035 With SCHED_DMA_INT_EN defined, the DMA interrupt source, DMA vector register and opcode 0011 behave as specified above.
REQ-036 Without SCHED_DMA_INT_EN, DMA_done is ignored, dma_pend is constant 0 and opcode 0011 is a no-op.

Verification
REQ-037 Start with value 5, no events -> timer_pend at 5th RUN cycle; INT_req=1, INT_addr=timer vector; INT_ack with PC_pos=0x0040 -> ISR; RETR -> SCHED_out=0x0040, valid for 1 cycle.
REQ-038 SYSCALL_req and DMA_done in the same RUN cycle with vectors 0x0100/0x0200 -> first INT_addr=0x0100; after ack+RETR -> second INT_addr=0x0200.
REQ-039 DMA_done during ISR -> no INT_req until RETR, then INT_req on the next RUN cycle.
REQ-040 PC command with PC_pos=0x1234 -> next cycle SCHED_out=0x1234, SCHED_out_valid=1, then 0.
REQ-041 Reset asserted while INT_req=1 -> next cycle all outputs 0, running=0; a subsequent SYSCALL_req before Start -> no INT_req.
REQ-042 Build without SCHED_DMA_INT_EN, pulse DMA_done in RUN -> INT_req stays 0.
